// File: rtl/candy_vend_ctrl.sv
// Vending controller: accumulates coin credit, tracks per-item stock, vends an
// affordable in-stock item for VEND_CYC cycles and refunds leftover credit as a
// train of unit change pulses (pulse, gap, pulse ...).
module candy_vend_ctrl #(
   parameter int                    N_ITEMS    = 5,
   parameter int                    CW         = 4,
   parameter int                    MAX_CREDIT = 15,
   parameter logic [N_ITEMS*CW-1:0] PRICES     = 20'h54321,
   parameter int                    STOCK_W    = 3,
   parameter int                    STOCK_INIT = 7,
   parameter int                    VEND_CYC   = 4,
   parameter int                    IW         = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               coin_valid,
   input  logic [CW-1:0]      coin_val,
   input  logic               sel_valid,
   input  logic [IW-1:0]      sel_idx,
   input  logic               cancel,
   input  logic               restock,
   output logic [CW-1:0]      credit,
   output logic [N_ITEMS-1:0] can_buy,
   output logic [N_ITEMS-1:0] sold_out,
   output logic               vend,
   output logic [IW-1:0]      vend_idx,
   output logic               change_pulse,
   output logic               reject,
   output logic               busy
);

   localparam logic [1:0] ACCEPT = 2'd0;
   localparam logic [1:0] VEND   = 2'd1;
   localparam logic [1:0] CHANGE = 2'd2;

   localparam int                 VCW      = $clog2(VEND_CYC + 1);
   localparam logic [VCW-1:0]     VEND_LD  = VCW'(VEND_CYC);
   localparam logic [STOCK_W-1:0] STOCK_LD = STOCK_W'(STOCK_INIT);
   localparam logic [CW:0]        MAX_SUM  = (CW+1)'(MAX_CREDIT);
   localparam logic [IW:0]        N_LIM    = (IW+1)'(N_ITEMS);

   logic [1:0]         state;
   logic [VCW-1:0]     vend_cnt;
   logic               chg_phase;
   logic [STOCK_W-1:0] stock [N_ITEMS];
   logic               sel_ok;

   function automatic logic [CW-1:0] price_of(input int i);
      return PRICES[i*CW +: CW];
   endfunction

   // Sum is formed one bit wider than credit so an overflowing coin cannot wrap.
   function automatic logic coin_fits(input logic [CW-1:0] cr, input logic [CW-1:0] c);
      logic [CW:0] sum;
      sum = {1'b0, cr} + {1'b0, c};
      return (sum <= MAX_SUM);
   endfunction

   // Per-item purchasability and sold-out flags derived from registered state.
   always_comb begin
      can_buy  = '0;
      sold_out = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         sold_out[i] = (stock[i] == '0);
         can_buy[i]  = (state == ACCEPT) && (stock[i] != '0) && (credit >= price_of(i));
      end
   end

   // A selection is honoured only for an in-range, currently purchasable item.
   always_comb begin
      sel_ok = 1'b0;
      if ({1'b0, sel_idx} < N_LIM) sel_ok = can_buy[sel_idx];
   end

   assign busy = (state != ACCEPT);

   // Main FSM: credit, stock, vend timing and change-pulse generation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ACCEPT;
         credit       <= '0;
         vend         <= 1'b0;
         vend_idx     <= '0;
         change_pulse <= 1'b0;
         reject       <= 1'b0;
         vend_cnt     <= '0;
         chg_phase    <= 1'b0;
         for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_LD;
      end else begin
         change_pulse <= 1'b0;
         reject       <= 1'b0;
         case (state)
            ACCEPT: begin
               if (cancel) begin
                  // A coin arriving alongside a higher-priority strobe is refused.
                  reject <= coin_valid;
                  if (credit != '0) begin
                     state     <= CHANGE;
                     chg_phase <= 1'b0;
                  end
               end else if (sel_valid) begin
                  reject <= coin_valid;
                  if (sel_ok) begin
                     credit          <= credit - price_of(int'(sel_idx));
                     stock[sel_idx]  <= stock[sel_idx] - STOCK_W'(1);
                     vend_idx        <= sel_idx;
                     vend            <= 1'b1;
                     vend_cnt        <= VEND_LD;
                     state           <= VEND;
                  end
               end else if (coin_valid) begin
                  if (coin_val != '0) begin
                     if (coin_fits(credit, coin_val)) credit <= credit + coin_val;
                     else                             reject <= 1'b1;
                  end
               end else if (restock) begin
                  for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_LD;
               end
            end
            VEND: begin
               reject <= coin_valid;
               if (vend_cnt == VCW'(1)) begin
                  vend      <= 1'b0;
                  vend_cnt  <= '0;
                  chg_phase <= 1'b0;
                  state     <= (credit != '0) ? CHANGE : ACCEPT;
               end else begin
                  vend_cnt <= vend_cnt - VCW'(1);
               end
            end
            CHANGE: begin
               reject <= coin_valid;
               if (!chg_phase) begin
                  change_pulse <= 1'b1;
                  credit       <= credit - CW'(1);
                  chg_phase    <= 1'b1;
               end else begin
                  chg_phase <= 1'b0;
                  if (credit == '0) state <= ACCEPT;
               end
            end
            default: state <= ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_candy_vend_ctrl.sv
// Scenario bench for candy_vend_ctrl: expected credit and vend indices are
// queued when stimulus is driven and popped when the design responds.
`timescale 1ns/1ps
module tb_candy_vend_ctrl;

   localparam int N_ITEMS = 5;
   localparam int CW      = 4;
   localparam int IW      = 3;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               coin_valid = 1'b0;
   logic [CW-1:0]      coin_val = '0;
   logic               sel_valid = 1'b0;
   logic [IW-1:0]      sel_idx = '0;
   logic               cancel = 1'b0;
   logic               restock = 1'b0;
   logic [CW-1:0]      credit;
   logic [N_ITEMS-1:0] can_buy;
   logic [N_ITEMS-1:0] sold_out;
   logic               vend;
   logic [IW-1:0]      vend_idx;
   logic               change_pulse;
   logic               reject;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;
   int model_credit = 0;
   int model_stock [N_ITEMS];
   int price_tab [N_ITEMS] = '{1, 2, 3, 4, 5};
   int credit_q [$];
   int vend_q [$];

   always #5 clk = ~clk;

   candy_vend_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_val     (coin_val),
      .sel_valid    (sel_valid),
      .sel_idx      (sel_idx),
      .cancel       (cancel),
      .restock      (restock),
      .credit       (credit),
      .can_buy      (can_buy),
      .sold_out     (sold_out),
      .vend         (vend),
      .vend_idx     (vend_idx),
      .change_pulse (change_pulse),
      .reject       (reject),
      .busy         (busy)
   );

   function automatic logic [N_ITEMS-1:0] model_can_buy();
      logic [N_ITEMS-1:0] r;
      r = '0;
      for (int i = 0; i < N_ITEMS; i++) r[i] = (model_stock[i] != 0) && (model_credit >= price_tab[i]);
      return r;
   endfunction

   function automatic logic [N_ITEMS-1:0] model_sold_out();
      logic [N_ITEMS-1:0] r;
      r = '0;
      for (int i = 0; i < N_ITEMS; i++) r[i] = (model_stock[i] == 0);
      return r;
   endfunction

   // Stimulus helpers: entered at a falling edge, return one falling edge later.
   task automatic pulse_coin(input int v);
      coin_valid = 1'b1; coin_val = CW'(v);
      @(negedge clk);
      coin_valid = 1'b0; coin_val = '0;
   endtask

   task automatic pulse_sel(input int idx);
      sel_valid = 1'b1; sel_idx = IW'(idx);
      @(negedge clk);
      sel_valid = 1'b0; sel_idx = '0;
   endtask

   task automatic pulse_cancel();
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
   endtask

   task automatic pulse_restock();
      restock = 1'b1;
      @(negedge clk);
      restock = 1'b0;
   endtask

   task automatic wait_idle(output int busy_cyc, output int vend_cyc, output int pulses, output bit timeout);
      busy_cyc = 0; vend_cyc = 0; pulses = 0; timeout = 1'b0;
      while (busy && !timeout) begin
         if (busy_cyc >= 200) begin
            timeout = 1'b1;
         end else begin
            busy_cyc++;
            if (vend) vend_cyc++;
            if (change_pulse) pulses++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({credit, busy, vend, change_pulse, reject, vend_idx} !== 11'h0) begin
         n_fail++;
         $display("FAIL reset_held: got %0h required 0", {credit, busy, vend, change_pulse, reject, vend_idx});
      end
      reset = 1'b1;
      for (int i = 0; i < N_ITEMS; i++) model_stock[i] = 7;
      model_credit = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({credit, can_buy, sold_out, busy, vend} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_idle_c%0d: got %0h required 0", c, {credit, can_buy, sold_out, busy, vend});
         end
      end
   endtask

   task automatic test_purchase();
      int coins [3] = '{2, 2, 1};
      int bc, vc, pc, exp;
      bit to;
      foreach (coins[k]) begin
         model_credit += coins[k];
         credit_q.push_back(model_credit);
         pulse_coin(coins[k]);
         exp = credit_q.pop_front();
         n_checks++;
         if (credit !== CW'(exp)) begin
            n_fail++;
            $display("FAIL purch_credit_%0d: got %0d required %0d", k, credit, exp);
         end
      end
      n_checks++;
      if (can_buy !== model_can_buy()) begin
         n_fail++;
         $display("FAIL purch_can_buy: got %b required %b", can_buy, model_can_buy());
      end
      vend_q.push_back(3);
      model_credit -= price_tab[3];
      model_stock[3]--;
      pulse_sel(3);
      exp = vend_q.pop_front();
      n_checks++;
      if (vend !== 1'b1 || vend_idx !== IW'(exp) || credit !== CW'(model_credit)) begin
         n_fail++;
         $display("FAIL purch_vend_start: got vend=%0b idx=%0d credit=%0d required 1 %0d %0d",
                  vend, vend_idx, credit, exp, model_credit);
      end
      wait_idle(bc, vc, pc, to);
      model_credit = 0;
      n_checks++;
      if (to !== 1'b0 || vc !== 4 || pc !== 1 || bc !== 6) begin
         n_fail++;
         $display("FAIL purch_timing: got to=%0b vend=%0d pulses=%0d busy=%0d required 0 4 1 6", to, vc, pc, bc);
      end
      n_checks++;
      if (credit !== '0 || int'(dut.stock[3]) !== model_stock[3]) begin
         n_fail++;
         $display("FAIL purch_end: got credit=%0d stock3=%0d required 0 %0d", credit, dut.stock[3], model_stock[3]);
      end
   endtask

   task automatic test_overflow();
      int coins [4] = '{10, 6, 5, 0};
      int bc, vc, pc, exp;
      bit to, exp_rej;
      foreach (coins[k]) begin
         exp_rej = (model_credit + coins[k] > 15);
         if (!exp_rej) model_credit += coins[k];
         credit_q.push_back(model_credit);
         pulse_coin(coins[k]);
         exp = credit_q.pop_front();
         n_checks++;
         if (credit !== CW'(exp) || reject !== exp_rej) begin
            n_fail++;
            $display("FAIL ovf_coin_%0d: got credit=%0d reject=%0b required %0d %0b", k, credit, reject, exp, exp_rej);
         end
      end
      n_checks++;
      if (can_buy !== model_can_buy()) begin
         n_fail++;
         $display("FAIL ovf_can_buy: got %b required %b", can_buy, model_can_buy());
      end
      pulse_cancel();
      n_checks++;
      if (busy !== 1'b1 || change_pulse !== 1'b0 || can_buy !== '0) begin
         n_fail++;
         $display("FAIL ovf_cancel: got busy=%0b pulse=%0b can_buy=%b required 1 0 0", busy, change_pulse, can_buy);
      end
      wait_idle(bc, vc, pc, to);
      n_checks++;
      if (to !== 1'b0 || pc !== 15 || bc !== 30 || vc !== 0 || credit !== '0) begin
         n_fail++;
         $display("FAIL ovf_refund: got to=%0b pulses=%0d busy=%0d vend=%0d credit=%0d required 0 15 30 0 0",
                  to, pc, bc, vc, credit);
      end
      model_credit = 0;
   endtask

   task automatic test_sold_out();
      int bc, vc, pc, exp, v;
      bit to;
      for (int k = 0; k < 7; k++) begin
         v = (k == 0) ? 5 : 1;
         model_credit += v;
         pulse_coin(v);
         vend_q.push_back(0);
         model_credit -= price_tab[0];
         model_stock[0]--;
         pulse_sel(0);
         exp = vend_q.pop_front();
         n_checks++;
         if (vend !== 1'b1 || vend_idx !== IW'(exp)) begin
            n_fail++;
            $display("FAIL sold_vend_%0d: got vend=%0b idx=%0d required 1 %0d", k, vend, vend_idx, exp);
         end
         wait_idle(bc, vc, pc, to);
         n_checks++;
         if (to !== 1'b0 || vc !== 4 || pc !== model_credit || bc !== 4 + 2 * model_credit) begin
            n_fail++;
            $display("FAIL sold_cycle_%0d: got to=%0b vend=%0d pulses=%0d busy=%0d required 0 4 %0d %0d",
                     k, to, vc, pc, bc, model_credit, 4 + 2 * model_credit);
         end
         model_credit = 0;
      end
      model_credit = 1;
      pulse_coin(1);
      n_checks++;
      if (sold_out !== model_sold_out() || can_buy !== model_can_buy()) begin
         n_fail++;
         $display("FAIL sold_flags: got sold=%b can=%b required %b %b", sold_out, can_buy, model_sold_out(), model_can_buy());
      end
      pulse_sel(0);
      n_checks++;
      if (vend !== 1'b0 || busy !== 1'b0 || credit !== CW'(model_credit)) begin
         n_fail++;
         $display("FAIL sold_ignored: got vend=%0b busy=%0b credit=%0d required 0 0 %0d", vend, busy, credit, model_credit);
      end
      for (int i = 0; i < N_ITEMS; i++) model_stock[i] = 7;
      pulse_restock();
      n_checks++;
      if (sold_out !== model_sold_out() || int'(dut.stock[0]) !== 7 || can_buy !== model_can_buy()) begin
         n_fail++;
         $display("FAIL sold_restock: got sold=%b stock0=%0d can=%b required %b 7 %b",
                  sold_out, dut.stock[0], can_buy, model_sold_out(), model_can_buy());
      end
      pulse_cancel();
      wait_idle(bc, vc, pc, to);
      n_checks++;
      if (to !== 1'b0 || pc !== 1 || bc !== 2 || vc !== 0 || credit !== '0) begin
         n_fail++;
         $display("FAIL sold_refund: got to=%0b pulses=%0d busy=%0d vend=%0d credit=%0d required 0 1 2 0 0",
                  to, pc, bc, vc, credit);
      end
      model_credit = 0;
   endtask

   task automatic test_priority();
      int bc, vc, pc;
      bit to;
      model_credit = 3;
      pulse_coin(3);
      cancel = 1'b1; sel_valid = 1'b1; sel_idx = '0; coin_valid = 1'b1; coin_val = CW'(1);
      @(negedge clk);
      cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_val = '0;
      n_checks++;
      if (busy !== 1'b1 || reject !== 1'b1 || vend !== 1'b0 || credit !== CW'(model_credit)) begin
         n_fail++;
         $display("FAIL prio_same_cycle: got busy=%0b rej=%0b vend=%0b credit=%0d required 1 1 0 %0d",
                  busy, reject, vend, credit, model_credit);
      end
      pulse_coin(2);
      n_checks++;
      if (reject !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_coin_in_change: got reject=%0b required 1", reject);
      end
      wait_idle(bc, vc, pc, to);
      n_checks++;
      if (to !== 1'b0 || pc !== 3 || credit !== '0) begin
         n_fail++;
         $display("FAIL prio_refund: got to=%0b pulses=%0d credit=%0d required 0 3 0", to, pc, credit);
      end
      model_credit = 2;
      pulse_coin(2);
      pulse_sel(6);
      n_checks++;
      if (vend !== 1'b0 || busy !== 1'b0 || credit !== CW'(model_credit)) begin
         n_fail++;
         $display("FAIL prio_bad_index: got vend=%0b busy=%0b credit=%0d required 0 0 %0d", vend, busy, credit, model_credit);
      end
      vend_q.push_back(1);
      model_credit -= price_tab[1];
      model_stock[1]--;
      pulse_sel(1);
      pulse_coin(3);
      n_checks++;
      if (reject !== 1'b1 || vend !== 1'b1 || vend_idx !== IW'(vend_q.pop_front()) || credit !== CW'(model_credit)) begin
         n_fail++;
         $display("FAIL prio_coin_in_vend: got rej=%0b vend=%0b idx=%0d credit=%0d required 1 1 1 %0d",
                  reject, vend, vend_idx, credit, model_credit);
      end
      wait_idle(bc, vc, pc, to);
      n_checks++;
      if (to !== 1'b0 || vc !== 3 || pc !== 0 || bc !== 3 || credit !== '0) begin
         n_fail++;
         $display("FAIL prio_vend_tail: got to=%0b vend=%0d pulses=%0d busy=%0d credit=%0d required 0 3 0 3 0",
                  to, vc, pc, bc, credit);
      end
   endtask

   task automatic test_reset_mid_change();
      bit stock_ok;
      model_credit = 4;
      pulse_coin(4);
      pulse_cancel();
      repeat (3) @(negedge clk);
      n_checks++;
      if (credit !== CW'(2) || busy !== 1'b1 || change_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pre: got credit=%0d busy=%0b pulse=%0b required 2 1 1", credit, busy, change_pulse);
      end
      #2 reset = 1'b0;
      #1;
      stock_ok = 1'b1;
      for (int i = 0; i < N_ITEMS; i++) if (int'(dut.stock[i]) !== 7) stock_ok = 1'b0;
      n_checks++;
      if (credit !== '0 || busy !== 1'b0 || change_pulse !== 1'b0 || vend !== 1'b0 || sold_out !== '0 || !stock_ok) begin
         n_fail++;
         $display("FAIL rst_mid_async: got credit=%0d busy=%0b pulse=%0b vend=%0b sold=%b stock_ok=%0b required 0 0 0 0 0 1",
                  credit, busy, change_pulse, vend, sold_out, stock_ok);
      end
      @(negedge clk);
      reset = 1'b1;
      model_credit = 0;
      for (int i = 0; i < N_ITEMS; i++) model_stock[i] = 7;
      repeat (2) @(negedge clk);
      n_checks++;
      if (credit !== '0 || busy !== 1'b0 || change_pulse !== 1'b0 || can_buy !== model_can_buy()) begin
         n_fail++;
         $display("FAIL rst_mid_after: got credit=%0d busy=%0b pulse=%0b can=%b required 0 0 0 %b",
                  credit, busy, change_pulse, can_buy, model_can_buy());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_purchase();
      test_overflow();
      test_sold_out();
      test_priority();
      test_reset_mid_change();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/candy_vend_ctrl.md
Name: candy_vend_ctrl

Overview:
Parametrised vending controller for N_ITEMS products.
- Accumulates coin credit and keeps a per-item stock count.
- Vends a selected item when it is affordable and in stock.
- Pays back any remaining credit as a train of unit change pulses.
- Sits between the debounced keypad/coin front end and the seven-segment display path; the credit and can_buy outputs feed the display and LEDs.

Parameters:
N_ITEMS, 5, number of products
CW, 4, credit/price width in coin units
MAX_CREDIT, 15, credit ceiling; must be <= 2^CW-1
PRICES, 20'h54321, flattened prices; item i = PRICES[i*CW +: CW]; default item0=1 .. item4=5
STOCK_W, 3, stock counter width
STOCK_INIT, 7, stock loaded at reset and on restock
VEND_CYC, 4, cycles vend is held high
IW, 3, select index width; must be >= clog2(N_ITEMS)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
coin_valid  in  1  one-cycle coin strobe
coin_val  in  CW  coin value in units, sampled when coin_valid=1
sel_valid  in  1  one-cycle product-select strobe
sel_idx  in  IW  selected product index
cancel  in  1  one-cycle refund request
restock  in  1  one-cycle restock-all request
credit  out  CW  current credit (registered)
can_buy  out  N_ITEMS  bit i=1: item i purchasable now
sold_out  out  N_ITEMS  bit i=1: stock[i]==0
vend  out  1  high for VEND_CYC cycles per sale
vend_idx  out  IW  item being vended; held while vend=1
change_pulse  out  1  one-cycle pulse per unit refunded
reject  out  1  one-cycle pulse: coin refused
busy  out  1  state != ACCEPT

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ACCEPT, credit=0, every stock[i]=STOCK_INIT.
  - vend=0, vend_idx=0, change_pulse=0, reject=0.
  - Internal counters are cleared.
  - Asserting reset mid-VEND or mid-CHANGE aborts at once; the lost credit is not refunded.
- FSM states: ACCEPT, VEND, CHANGE. All registered outputs update on the clk rising edge following the input strobe (1-cycle latency).
- ACCEPT, same-cycle priority is cancel > sel_valid > coin_valid > restock. Only the highest-priority strobe acts; a lower-priority coin is rejected; the others are dropped.
  - cancel:
    - credit>0 -> CHANGE.
    - credit==0 -> no effect.
  - sel_valid with sel_idx<N_ITEMS and can_buy[sel_idx]=1:
    - credit -= price.
    - stock[sel_idx] -= 1.
    - vend_idx = sel_idx, vend=1.
    - Counter loaded with VEND_CYC; go to VEND.
  - sel_valid otherwise (index out of range, unaffordable or sold out): ignored, no state change.
  - coin_valid:
    - coin_val==0 -> ignored.
    - credit+coin_val <= MAX_CREDIT -> credit += coin_val. The sum is computed at CW+1 bits so it cannot wrap.
    - otherwise -> reject=1 for one cycle; credit unchanged.
  - restock: every stock[i] = STOCK_INIT.
- VEND:
  - vend stays high for exactly VEND_CYC cycles.
  - On the last cycle, go to CHANGE if credit>0, else to ACCEPT.
- CHANGE:
  - change_pulse=1 on alternate cycles (pulse, gap, pulse ...).
  - credit decrements by 1 on each pulse.
  - After the pulse that brings credit to 0, go to ACCEPT on the next cycle.
  - A refund of k units takes 2k cycles.
- In VEND and CHANGE:
  - coin_valid always gives reject=1.
  - sel_valid, cancel and restock are ignored.
- Combinational outputs, from registered state only:
  - can_buy[i] = (state==ACCEPT) & (stock[i]!=0) & (credit>=price[i]).
  - sold_out[i] = (stock[i]==0).
  - busy = (state!=ACCEPT).
- Stock never decrements below 0; this is guaranteed by the can_buy gating.
- A price of 0 is allowed: the item needs only stock and vends with credit 0.

Test Plan:
- Reset held low, then released -> credit=0, can_buy=0, sold_out=0, busy=0, vend=0 for >=3 cycles.
- Coins 2,2,1 then sel_idx=3 (price 4) -> credit 5; vend=1 for 4 cycles with vend_idx=3; then 1 change_pulse; credit ends 0; stock[3]=6; busy drops after 6+ cycles.
- Coins 10 then 6 -> second coin gives reject=1, credit stays 10. Coin 5 -> credit 15. Cancel -> 15 change_pulses over 30 cycles, credit 0.
- Credit 5, buy item0 (price 1) seven times, topping credit up as needed -> sold_out[0]=1, can_buy[0]=0. Eighth sel_idx=0 is ignored. restock -> sold_out[0]=0, stock[0]=7.
- Same-cycle cancel+sel_valid+coin_valid with credit 3 -> CHANGE entered, reject=1, no vend. Coin during VEND -> reject=1, credit unchanged.
- reset pulsed low mid-CHANGE with credit 4 -> immediately state=ACCEPT, credit=0, change_pulse=0, stocks=STOCK_INIT.
